// File: rtl/datapath_pipe.sv
// Two-stage register-file datapath: operand read + ALU in stage 1, result/flags
// register and write-back in stage 2, with WB->EX forwarding and an external load port.
module datapath_pipe #(
  parameter int WIDTH = 32,
  parameter int NREGS = 8,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alucontrol,
  input  logic [AW-1:0]    addr1,
  input  logic [AW-1:0]    addr2,
  input  logic [AW-1:0]    addr3,
  input  logic             wr,
  input  logic             ld_en,
  output logic             ld_ready,
  input  logic [AW-1:0]    ld_addr,
  input  logic [WIDTH-1:0] ld_data,
  output logic [WIDTH-1:0] data1,
  output logic [WIDTH-1:0] data2,
  output logic [WIDTH-1:0] result,
  output logic             res_valid,
  output logic [3:0]       flags
);
  localparam int SW = $clog2(WIDTH);

  logic [WIDTH-1:0] rf [NREGS];
  logic             wb_wr;
  logic [AW-1:0]    wb_addr;
  logic             wb_fwd;
  logic             ld_take;
  logic             accept;

  // Handshakes: an op transfers when in_valid && in_ready, a load when ld_en && ld_ready.
  // A pending write-back blocks loads; an accepted load blocks ops for that cycle,
  // so the RF write port is never contended.
  assign wb_fwd   = res_valid && wb_wr;
  assign ld_ready = ~wb_fwd;
  assign ld_take  = ld_en && ld_ready;
  assign in_ready = ~ld_take;
  assign accept   = in_valid && in_ready;

  assign data1 = (wb_fwd && (wb_addr == addr1)) ? result : rf[addr1];
  assign data2 = (wb_fwd && (wb_addr == addr2)) ? result : rf[addr2];

  logic [WIDTH:0]   add_full;
  logic [WIDTH:0]   sub_full;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;

  assign add_full = {1'b0, data1} + {1'b0, data2};
  assign sub_full = {1'b0, data1} - {1'b0, data2};

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (alucontrol)
      3'b000: begin
        alu_res = add_full[WIDTH-1:0];
        alu_c   = add_full[WIDTH];
        alu_v   = (data1[WIDTH-1] == data2[WIDTH-1]) && (add_full[WIDTH-1] != data1[WIDTH-1]);
      end
      3'b001: begin
        alu_res = sub_full[WIDTH-1:0];
        alu_c   = sub_full[WIDTH];
        alu_v   = (data1[WIDTH-1] != data2[WIDTH-1]) && (sub_full[WIDTH-1] != data1[WIDTH-1]);
      end
      3'b010: alu_res = data1 & data2;
      3'b011: alu_res = data1 ^ data2;
      3'b100: alu_res = data1 | data2;
      3'b101: alu_res = {{(WIDTH-1){1'b0}}, ($signed(data1) < $signed(data2))};
      3'b110: alu_res = data1 << data2[SW-1:0];
      default: alu_res = data1 >> data2[SW-1:0];
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_valid <= 1'b0;
      wb_wr     <= 1'b0;
      wb_addr   <= '0;
      result    <= '0;
      flags     <= '0;
    end else begin
      res_valid <= accept;
      if (accept) begin
        wb_wr   <= wr;
        wb_addr <= addr3;
        result  <= alu_res;
        flags   <= {(alu_res == '0), alu_res[WIDTH-1], alu_c, alu_v};
      end
    end
  end

  // Write-back and load are mutually exclusive by the ld_ready rule.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (wb_fwd) begin
      rf[wb_addr] <= result;
    end else if (ld_take) begin
      rf[ld_addr] <= ld_data;
    end
  end
endmodule

// File: tb/tb_datapath_pipe.sv
// Self-checking bench for datapath_pipe: directed scenarios plus random ops and loads
// compared against an architectural (in-order, immediately committed) register model.
module tb_datapath_pipe;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  alucontrol = '0;
  logic [2:0]  addr1 = '0, addr2 = '0, addr3 = '0;
  logic        wr = 1'b0;
  logic        ld_en = 1'b0;
  logic        ld_ready;
  logic [2:0]  ld_addr = '0;
  logic [31:0] ld_data = '0;
  logic [31:0] data1, data2, result;
  logic        res_valid;
  logic [3:0]  flags;

  datapath_pipe #(.WIDTH(32), .NREGS(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alucontrol(alucontrol), .addr1(addr1), .addr2(addr2), .addr3(addr3), .wr(wr),
    .ld_en(ld_en), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .data1(data1), .data2(data2), .result(result), .res_valid(res_valid), .flags(flags)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] arch [8];
  logic [31:0] exp_result = '0;
  logic [3:0]  exp_flags = '0;
  logic        exp_res_valid = 1'b0;
  logic        last_wr = 1'b0;
  logic        obs_ld_ready, obs_in_ready;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void alu_model(input logic [31:0] a, input logic [31:0] b,
                                    input logic [2:0] op,
                                    output logic [31:0] r, output logic [3:0] f);
    longint sa, sb, sr;
    logic c, v;
    sa = $signed(a);
    sb = $signed(b);
    sr = 0;
    c = 1'b0;
    v = 1'b0;
    case (op)
      3'd0: begin
        r  = a + b;
        c  = ({32'd0, a} + {32'd0, b}) > 64'hFFFF_FFFF;
        sr = sa + sb;
        v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      3'd1: begin
        r  = a - b;
        c  = a < b;
        sr = sa - sb;
        v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      3'd2: r = a & b;
      3'd3: r = a ^ b;
      3'd4: r = a | b;
      3'd5: r = (sa < sb) ? 32'd1 : 32'd0;
      3'd6: r = a << b[4:0];
      default: r = a >> b[4:0];
    endcase
    f = {(r == 32'd0), r[31], c, v};
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 8; i++) arch[i] = '0;
    exp_result = '0;
    exp_flags = '0;
    exp_res_valid = 1'b0;
    last_wr = 1'b0;
  endtask

  // One clock cycle: drive, sample at negedge, then advance the model.
  task automatic cycle(input logic iv, input logic [2:0] op, input logic [2:0] a1,
                       input logic [2:0] a2, input logic [2:0] a3, input logic w,
                       input logic le, input logic [2:0] la, input logic [31:0] ld);
    logic        exp_ldr, exp_inr, acc;
    logic [31:0] r;
    logic [3:0]  f;
    in_valid = iv; alucontrol = op; addr1 = a1; addr2 = a2; addr3 = a3; wr = w;
    ld_en = le; ld_addr = la; ld_data = ld;
    @(negedge clk);
    check_eq("res_valid", {31'd0, res_valid}, {31'd0, exp_res_valid});
    check_eq("result", result, exp_result);
    check_eq("flags", {28'd0, flags}, {28'd0, exp_flags});
    check_eq("data1", data1, arch[a1]);
    check_eq("data2", data2, arch[a2]);
    exp_ldr = !last_wr;
    exp_inr = !(le && exp_ldr);
    check_eq("ld_ready", {31'd0, ld_ready}, {31'd0, exp_ldr});
    check_eq("in_ready", {31'd0, in_ready}, {31'd0, exp_inr});
    obs_ld_ready = ld_ready;
    obs_in_ready = in_ready;
    acc = iv && exp_inr;
    r = '0;
    f = '0;
    if (acc) begin
      alu_model(arch[a1], arch[a2], op, r, f);
      exp_result = r;
      exp_flags = f;
    end
    exp_res_valid = acc;
    last_wr = acc && w;
    if (le && exp_ldr) arch[la] = ld;
    if (acc && w) arch[a3] = r;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [2:0] a, input logic [31:0] d);
    cycle(1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1, a, d);
  endtask

  task automatic op(input logic [2:0] o, input logic [2:0] a1, input logic [2:0] a2,
                    input logic [2:0] a3, input logic w);
    cycle(1'b1, o, a1, a2, a3, w, 1'b0, 3'd0, 32'd0);
  endtask

  task automatic idle(input logic [2:0] a1, input logic [2:0] a2);
    cycle(1'b0, 3'd0, a1, a2, 3'd0, 1'b0, 1'b0, 3'd0, 32'd0);
  endtask

  initial begin
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_res_valid", {31'd0, res_valid}, 32'd0);
    check_eq("rst_result", result, 32'd0);
    rst = 1'b1;
    idle(3'd0, 3'd7);

    // 1: reset mid-op loses the pending write and clears loaded registers
    load(3'd1, 32'd5);
    load(3'd2, 32'd7);
    op(3'd0, 3'd1, 3'd2, 3'd3, 1'b1);
    rst = 1'b0;
    #1;
    check_eq("t1_res_valid", {31'd0, res_valid}, 32'd0);
    check_eq("t1_result", result, 32'd0);
    check_eq("t1_flags", {28'd0, flags}, 32'd0);
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    idle(3'd1, 3'd2);
    check_eq("t1_r1", data1, 32'd0);
    idle(3'd3, 3'd3);
    check_eq("t1_r3", data1, 32'd0);

    // 2: add with forwarded readback of the destination
    load(3'd1, 32'd5);
    load(3'd2, 32'd7);
    op(3'd0, 3'd1, 3'd2, 3'd0, 1'b1);
    check_eq("t2_result", result, 32'd12);
    check_eq("t2_valid", {31'd0, res_valid}, 32'd1);
    check_eq("t2_flags", {28'd0, flags}, 32'd0);
    idle(3'd0, 3'd0);

    // 3: back-to-back dependent ops
    op(3'd0, 3'd1, 3'd2, 3'd3, 1'b1);
    op(3'd3, 3'd3, 3'd1, 3'd4, 1'b1);
    check_eq("t3_result", result, 32'd9);
    idle(3'd4, 3'd4);
    idle(3'd4, 3'd3);

    // 4: sub flags
    op(3'd1, 3'd1, 3'd2, 3'd5, 1'b1);
    check_eq("t4_sub", result, 32'hFFFF_FFFE);
    check_eq("t4_flags", {28'd0, flags}, 32'b0110);
    op(3'd1, 3'd1, 3'd1, 3'd5, 1'b0);
    check_eq("t4_zero", result, 32'd0);
    check_eq("t4_zflags", {28'd0, flags}, 32'b1000);

    // 5: signed overflow, then shift into the sign bit
    load(3'd6, 32'h7FFF_FFFF);
    load(3'd7, 32'd1);
    load(3'd5, 32'd31);
    op(3'd0, 3'd6, 3'd7, 3'd3, 1'b1);
    check_eq("t5_add", result, 32'h8000_0000);
    check_eq("t5_aflags", {28'd0, flags}, 32'b0101);
    op(3'd6, 3'd7, 3'd5, 3'd4, 1'b1);
    check_eq("t5_shl", result, 32'h8000_0000);
    check_eq("t5_sflags", {28'd0, flags}, 32'b0100);

    // 6: load blocked by pending write-back, accepted the next cycle
    op(3'd4, 3'd1, 3'd2, 3'd0, 1'b1);
    cycle(1'b0, 3'd0, 3'd0, 3'd2, 3'd0, 1'b0, 1'b1, 3'd2, 32'hABCD_0123);
    check_eq("t6_ld_block", {31'd0, obs_ld_ready}, 32'd0);
    cycle(1'b1, 3'd0, 3'd0, 3'd2, 3'd1, 1'b1, 1'b1, 3'd2, 32'hABCD_0123);
    check_eq("t6_ld_take", {31'd0, obs_ld_ready}, 32'd1);
    check_eq("t6_in_block", {31'd0, obs_in_ready}, 32'd0);
    idle(3'd0, 3'd2);
    check_eq("t6_r0", data1, 32'd7);
    check_eq("t6_r2", data2, 32'hABCD_0123);

    // random ops and loads
    for (int n = 0; n < 600; n++) begin
      logic [31:0] d;
      d = $urandom_range(0, 3) == 0 ? 32'h8000_0000 + $urandom_range(0, 3) : $urandom;
      cycle($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
            $urandom_range(0, 3) == 0, 3'($urandom_range(0, 7)), d);
    end
    for (int i = 0; i < 8; i += 2) idle(3'(i), 3'(i + 1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
